// File: rtl/flit_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one flit FIFO write port among NUM_REQ requesters.
// A granted requester owns the port until FLITS flits have been accepted.
module flit_packet_arbiter #(
  parameter int unsigned INPUT_WIDTH = 128,
  parameter int unsigned FLITS       = 5,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned CNT_BITS    = 3
) (
  input  logic                           clk_in,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_in,
  input  logic [NUM_REQ-1:0]             valid_in,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]             gnt_out,
  output logic                           fifo_wr_en,
  output logic [INPUT_WIDTH-1:0]         fifo_data_out,
  output logic                           sop_out,
  output logic                           eop_out,
  output logic                           busy_out,
  output logic [15:0]                    pkt_count_out
);

  localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PKT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [OWN_W-1:0]       owner_q, owner_d;
  logic [OWN_W-1:0]       last_q, last_d;
  logic [CNT_BITS-1:0]    idx_q, idx_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic                   wr_q, wr_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic                   busy_q, busy_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic [PKT_W-1:0]       pkt_count_q, pkt_count_d;

  logic                   pick_vld_c;
  logic [OWN_W-1:0]       pick_c;
  logic [OWN_W-1:0]       cand_c;
  logic                   own_vld_c;
  logic [INPUT_WIDTH-1:0] own_data_c;
  logic                   last_flit_c;

  // Round-robin search starting just after the previous owner
  always_comb begin
    pick_vld_c = 1'b0;
    pick_c     = '0;
    cand_c     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_c = OWN_W'((32'(last_q) + k) % NUM_REQ);
      if (!pick_vld_c && req_in[cand_c]) begin
        pick_vld_c = 1'b1;
        pick_c     = cand_c;
      end
    end
  end

  assign own_vld_c   = valid_in[owner_q];
  assign own_data_c  = data_in[32'(owner_q) * INPUT_WIDTH +: INPUT_WIDTH];
  assign last_flit_c = (idx_q == CNT_BITS'(FLITS - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    wr_d        = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    busy_d      = busy_q;
    data_d      = data_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          state_d = ST_XFER;
          owner_d = pick_c;
          gnt_d   = NUM_REQ'(1) << pick_c;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      ST_XFER: begin
        if (own_vld_c) begin
          wr_d   = 1'b1;
          data_d = own_data_c;
          sop_d  = (idx_q == '0);
          eop_d  = last_flit_c;
          idx_d  = idx_q + CNT_BITS'(1);
          if (last_flit_c) begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            busy_d      = 1'b0;
            idx_d       = '0;
            last_d      = owner_q;
            pkt_count_d = pkt_count_q + PKT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= OWN_W'(NUM_REQ - 1);
      idx_q       <= '0;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign gnt_out       = gnt_q;
  assign fifo_wr_en    = wr_q;
  assign fifo_data_out = data_q;
  assign sop_out       = sop_q;
  assign eop_out       = eop_q;
  assign busy_out      = busy_q;
  assign pkt_count_out = pkt_count_q;

endmodule
